prbs_gen_chk: RTL and testbench
===============================

PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter W, default 8: bits generated/checked per cycle, legal range 1..8.
REQ-002 SHALL have parameter ERR_W, default 16: error counter width.
REQ-003 SHALL have parameter LOCK_WORDS, default 4: consecutive clean words needed to lock.
REQ-004 SHALL have parameter LOSS_WORDS, default 4: consecutive errored words needed to drop lock.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  generator advance enable.
- mode  in  2  polynomial select: 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31.
- inject_err  in  1  invert one generated bit.
- gen_data  out  W  generated word, MSB first in time.
- gen_valid  out  1  gen_data is new this cycle.
- chk_data  in  W  received word, MSB first in time.
- chk_valid  in  1  chk_data is valid.
- clr_cnt  in  1  clear error counter.
- locked  out  1  checker synchronised.
- err_cnt  out  ERR_W  saturating bit-error count.
- err_sat  out  1  err_cnt at all-ones.

Function
REQ-006 Polynomials SHALL be Fibonacci LFSRs: x^7+x^6+1, x^15+x^14+1, x^23+x^18+1, x^31+x^28+1.
REQ-007 Each step SHALL compute new=s[a-1]^s[b-1] (a, b = exponents), shift state left, insert new at s[0], and emit new.
REQ-008 The generator SHALL take W steps per cycle when en=1, registering the bits to gen_data (first bit to gen_data[W-1]), with gen_valid=1 the following cycle.
REQ-009 When en=0, gen_data SHALL hold, gen_valid SHALL be 0 and the LFSR SHALL not advance.
REQ-010 inject_err=1 with en=1 SHALL invert gen_data[W-1] for that word only, leaving LFSR state unaffected.
REQ-011 A change of mode vs. the previous cycle SHALL reload the generator seed (all ones in the active width) without output that cycle, force the checker to SEARCH and zero its clean/bad counters.
REQ-012 The checker SHALL use the same W-step function; per word, predicted bit i = taps of checker state and err_bits = popcount(received ^ predicted).
REQ-013 Checker FSM SHALL have states SEARCH and LOCKED, and SHALL act only on cycles with chk_valid=1.
REQ-014 In SEARCH, the checker SHALL shift received bits into its state (self-synchronising).
REQ-015 In SEARCH, an error-free word with nonzero checker state SHALL increment clean_cnt; an errored word or all-zero state SHALL clear clean_cnt.
REQ-016 Transition SEARCH->LOCKED SHALL occur on the word making clean_cnt=LOCK_WORDS.
REQ-017 In LOCKED, the checker SHALL shift predicted bits (free-running) and add err_bits to err_cnt, saturating at 2^ERR_W-1.
REQ-018 In LOCKED, an errored word SHALL increment bad_cnt and a clean word SHALL clear it; transition LOCKED->SEARCH SHALL occur on the word making bad_cnt=LOSS_WORDS.
REQ-019 locked and err_cnt SHALL update the cycle after the sampling edge (latency 1).
REQ-020 clr_cnt SHALL zero err_cnt; if clr_cnt coincides with an errored word, clear SHALL win.
REQ-021 err_sat SHALL equal &err_cnt.

Reset
REQ-022 rst=1 SHALL set generator and checker state to all ones, gen_data=0, gen_valid=0, locked=0, err_cnt=0, err_sat=0, FSM=SEARCH, clean_cnt=bad_cnt=0.
REQ-023 rst SHALL take priority over en, clr_cnt, mode change and chk_valid; reset mid-lock SHALL drop locked the next cycle.

Structure
REQ-024 Package prbs_pkg SHALL hold the mode enum, tap-pair table, seed constant and FSM state enum.
REQ-025 A combinational sub-module prbs_step (inputs: state, mode, feed bits, feed select; outputs: next state, emitted bits) SHALL be instantiated once for the generator and once for the checker.

Verification
REQ-026 Reset, mode=0, W=8, en=1 -> first gen_data=0x02, gen_valid=1.
REQ-027 gen_data looped to chk_data, all modes -> locked=1 within LOCK_WORDS+ceil(order/W) words, err_cnt stays 0.
REQ-028 Locked loopback, inject_err pulsed 3 times -> err_cnt=3, locked stays 1.
REQ-029 Locked, chk_data forced to 0x00 -> locked=0 after exactly 4 words; relock never occurs while data is all zero.
REQ-030 ERR_W=4, random data while locked -> err_cnt saturates at 15, err_sat=1; clr_cnt with errored word -> err_cnt=0.
REQ-031 Mode change mid-lock -> locked=0 next cycle; relocks on the new polynomial; rst mid-operation -> REQ-022 values.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial select, tap table, seed helpers and checker states.
package prbs_pkg;

   localparam int SW = 31;
   localparam logic [SW-1:0] SEED_ONES = '1;

   typedef enum logic [1:0] {
      MODE_PRBS7  = 2'd0,
      MODE_PRBS15 = 2'd1,
      MODE_PRBS23 = 2'd2,
      MODE_PRBS31 = 2'd3
   } mode_e;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } chk_fsm_e;

   // Polynomial exponents x^a + x^b + 1; a is also the LFSR order.
   typedef struct packed {
      logic [4:0] a;
      logic [4:0] b;
   } tap_pair_t;

   localparam tap_pair_t [3:0] TAP_TBL = {
      tap_pair_t'{a: 5'd31, b: 5'd28},
      tap_pair_t'{a: 5'd23, b: 5'd18},
      tap_pair_t'{a: 5'd15, b: 5'd14},
      tap_pair_t'{a: 5'd7,  b: 5'd6}
   };

   function automatic logic [SW-1:0] mask_of(input mode_e m);
      return SEED_ONES >> (SW - int'(TAP_TBL[m].a));
   endfunction

endpackage

// File: rtl/prbs_step.sv
// W Fibonacci LFSR steps in one cycle; feed_sel_i shifts in external bits instead of the tap result.
module prbs_step
   import prbs_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [SW-1:0] state_i,
   input  mode_e         mode_i,
   input  logic [W-1:0]  feed_i,
   input  logic          feed_sel_i,
   output logic [SW-1:0] state_o,
   output logic [W-1:0]  bits_o
);

   tap_pair_t     tp;
   logic [4:0]    ia;
   logic [4:0]    ib;
   logic [SW-1:0] msk;
   logic [SW-1:0] st;
   logic          nb;

   always_comb begin
      tp     = TAP_TBL[mode_i];
      ia     = tp.a - 5'd1;
      ib     = tp.b - 5'd1;
      msk    = mask_of(mode_i);
      st     = state_i & msk;
      nb     = 1'b0;
      bits_o = '0;
      // Earliest bit lands in the MSB so the word reads MSB first in time.
      for (int i = 0; i < W; i++) begin
         nb            = st[ia] ^ st[ib];
         bits_o[W-1-i] = nb;
         st            = {st[SW-2:0], (feed_sel_i ? feed_i[W-1-i] : nb)} & msk;
      end
      state_o = st;
   end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 word generator plus self-synchronising checker with lock tracking and error count.
module prbs_gen_chk
   import prbs_pkg::*;
#(
   parameter int W          = 8,
   parameter int ERR_W      = 16,
   parameter int LOCK_WORDS = 4,
   parameter int LOSS_WORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             inject_err,
   output logic [W-1:0]     gen_data,
   output logic             gen_valid,
   input  logic [W-1:0]     chk_data,
   input  logic             chk_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt,
   output logic             err_sat
);

   localparam int CW = $clog2((LOCK_WORDS > LOSS_WORDS ? LOCK_WORDS : LOSS_WORDS) + 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   function automatic logic [3:0] popcount(input logic [W-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < W; i++) c = c + {3'd0, v[i]};
      return c;
   endfunction

   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [3:0] b);
      logic [ERR_W+3:0] s;
      s = {4'd0, a} + {{ERR_W{1'b0}}, b};
      return (s > {4'd0, ERR_MAX}) ? ERR_MAX : s[ERR_W-1:0];
   endfunction

   mode_e         mode_cur;
   logic [1:0]    mode_q;
   logic          mode_chg;

   logic [SW-1:0] gen_state_q, gen_state_d, gen_next;
   logic [W-1:0]  gen_data_q, gen_data_d, gen_bits;
   logic          gen_valid_q, gen_valid_d;
   logic [W-1:0]  inj_mask;

   logic [SW-1:0] chk_state_q, chk_next;
   logic [W-1:0]  chk_bits;
   chk_fsm_e      fsm_q;
   logic [CW-1:0] clean_q, bad_q;
   logic [ERR_W-1:0] err_q;
   logic [3:0]    err_bits;
   logic          chk_feed;

   assign mode_cur = mode_e'(mode);
   assign mode_chg = (mode != mode_q);

   prbs_step #(.W(W)) u_gen_step (
      .state_i   (gen_state_q),
      .mode_i    (mode_cur),
      .feed_i    ('0),
      .feed_sel_i(1'b0),
      .state_o   (gen_next),
      .bits_o    (gen_bits)
   );

   assign chk_feed = (fsm_q == ST_SEARCH);

   prbs_step #(.W(W)) u_chk_step (
      .state_i   (chk_state_q),
      .mode_i    (mode_cur),
      .feed_i    (chk_data),
      .feed_sel_i(chk_feed),
      .state_o   (chk_next),
      .bits_o    (chk_bits)
   );

   always_comb begin
      inj_mask      = '0;
      inj_mask[W-1] = inject_err;
   end

   always_comb begin
      gen_state_d = gen_state_q;
      gen_data_d  = gen_data_q;
      gen_valid_d = 1'b0;
      if (mode_chg) begin
         gen_state_d = mask_of(mode_cur);
      end else if (en) begin
         gen_state_d = gen_next;
         gen_data_d  = gen_bits ^ inj_mask;
         gen_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gen_state_q <= SEED_ONES;
         gen_data_q  <= '0;
         gen_valid_q <= 1'b0;
         mode_q      <= mode;
      end else begin
         gen_state_q <= gen_state_d;
         gen_data_q  <= gen_data_d;
         gen_valid_q <= gen_valid_d;
         mode_q      <= mode;
      end
   end

   assign err_bits = popcount(chk_data ^ chk_bits);

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_state_q <= SEED_ONES;
         fsm_q       <= ST_SEARCH;
         clean_q     <= '0;
         bad_q       <= '0;
         err_q       <= '0;
      end else begin
         if (mode_chg) begin
            chk_state_q <= mask_of(mode_cur);
            fsm_q       <= ST_SEARCH;
            clean_q     <= '0;
            bad_q       <= '0;
         end else if (chk_valid) begin
            chk_state_q <= chk_next;
            case (fsm_q)
               ST_SEARCH: begin
                  // A zero state would predict zeros forever, so it never counts as clean.
                  if (err_bits == 4'd0 && |chk_next) begin
                     if (clean_q == CW'(LOCK_WORDS - 1)) begin
                        fsm_q   <= ST_LOCKED;
                        clean_q <= '0;
                        bad_q   <= '0;
                     end else begin
                        clean_q <= clean_q + 1'b1;
                     end
                  end else begin
                     clean_q <= '0;
                  end
               end
               ST_LOCKED: begin
                  err_q <= sat_add(err_q, err_bits);
                  if (err_bits != 4'd0) begin
                     if (bad_q == CW'(LOSS_WORDS - 1)) begin
                        fsm_q   <= ST_SEARCH;
                        clean_q <= '0;
                        bad_q   <= '0;
                     end else begin
                        bad_q <= bad_q + 1'b1;
                     end
                  end else begin
                     bad_q <= '0;
                  end
               end
               default: fsm_q <= ST_SEARCH;
            endcase
         end
         if (clr_cnt) err_q <= '0;
      end
   end

   assign gen_data  = gen_data_q;
   assign gen_valid = gen_valid_q;
   assign locked    = (fsm_q == ST_LOCKED);
   assign err_cnt   = err_q;
   assign err_sat   = &err_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench: generator words, loopback lock, injection, saturation, loss of lock, mode change, reset.
module tb_prbs_gen_chk;

   logic       clk = 1'b0;
   logic       rst, en, inject_err, clr_cnt;
   logic [1:0] mode;
   logic [1:0] dsel;
   logic [7:0] gen_data, gen_data4, chk_data;
   logic       gen_valid, gen_valid4, chk_valid;
   logic       locked, locked4, err_sat, err_sat4;
   logic [15:0] err_cnt;
   logic [3:0]  err_cnt4;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // 0: loopback, 1: inverted loopback, 2: all zeros
   always_comb begin
      case (dsel)
         2'd0:    chk_data = gen_data;
         2'd1:    chk_data = ~gen_data;
         default: chk_data = 8'h00;
      endcase
   end
   assign chk_valid = gen_valid;

   prbs_gen_chk dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .inject_err(inject_err),
      .gen_data(gen_data), .gen_valid(gen_valid), .chk_data(chk_data),
      .chk_valid(chk_valid), .clr_cnt(clr_cnt), .locked(locked),
      .err_cnt(err_cnt), .err_sat(err_sat)
   );

   prbs_gen_chk #(.ERR_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .inject_err(inject_err),
      .gen_data(gen_data4), .gen_valid(gen_valid4), .chk_data(chk_data),
      .chk_valid(chk_valid), .clr_cnt(clr_cnt), .locked(locked4),
      .err_cnt(err_cnt4), .err_sat(err_sat4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_lock(input int budget, input string tag);
      int n;
      n = 0;
      while (!locked && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(locked), 32'd1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 2'd0; inject_err = 1'b0; clr_cnt = 1'b0; dsel = 2'd0;
      tick(); tick();
      chk("rst gen_data",  32'(gen_data),  32'h0);
      chk("rst gen_valid", 32'(gen_valid), 32'd0);
      chk("rst locked",    32'(locked),    32'd0);
      chk("rst err_cnt",   32'(err_cnt),   32'd0);
      chk("rst err_sat",   32'(err_sat),   32'd0);

      // PRBS7 from all-ones seed: 02 0C 28 F2
      rst = 1'b0;
      tick();
      chk("word0",        32'(gen_data),   32'h02);
      chk("word0 valid",  32'(gen_valid),  32'd1);
      chk("dut4 word0",   32'(gen_data4),  32'h02);
      chk("dut4 valid",   32'(gen_valid4), 32'd1);
      tick();
      chk("word1",        32'(gen_data),   32'h0C);
      en = 1'b0;
      tick();
      chk("en0 hold",     32'(gen_data),   32'h0C);
      chk("en0 valid",    32'(gen_valid),  32'd0);
      en = 1'b1; inject_err = 1'b1;
      tick();
      chk("inject word2", 32'(gen_data),   32'hA8);
      inject_err = 1'b0;
      tick();
      chk("word3 after inject", 32'(gen_data), 32'hF2);

      // Loopback lock: first word at edge 1, four clean words at edges 2..5
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst mid search locked", 32'(locked), 32'd0);
      tick(); tick(); tick(); tick();
      chk("not yet locked", 32'(locked), 32'd0);
      tick();
      chk("locked PRBS7",   32'(locked), 32'd1);
      chk("lock err_cnt",   32'(err_cnt), 32'd0);

      for (int k = 0; k < 3; k++) begin
         inject_err = 1'b1;
         tick();
         inject_err = 1'b0;
         tick(); tick();
      end
      tick();
      chk("inject err_cnt",      32'(err_cnt),  32'd3);
      chk("inject err_cnt4",     32'(err_cnt4), 32'd3);
      chk("inject keeps locked", 32'(locked),   32'd1);

      // Saturation: two fully inverted words = 16 bit errors
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("clr err_cnt", 32'(err_cnt), 32'd0);
      dsel = 2'd1;
      tick(); tick();
      dsel = 2'd0;
      chk("16b err_cnt",  32'(err_cnt),  32'd16);
      chk("4b saturated", 32'(err_cnt4), 32'd15);
      chk("4b err_sat",   32'(err_sat4), 32'd1);
      chk("16b err_sat",  32'(err_sat),  32'd0);
      chk("sat locked4",  32'(locked4),  32'd1);
      tick();
      dsel = 2'd1; clr_cnt = 1'b1;
      tick();
      chk("clr wins",     32'(err_cnt),  32'd0);
      chk("clr wins 4b",  32'(err_cnt4), 32'd0);
      chk("clr err_sat4", 32'(err_sat4), 32'd0);
      dsel = 2'd0; clr_cnt = 1'b0;
      tick();
      chk("still locked", 32'(locked), 32'd1);

      // All-zero data: lock lost on the fourth word, never regained
      dsel = 2'd2;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("zero hold lock", 32'(locked), 32'd1);
      end
      tick();
      chk("zero lost lock", 32'(locked), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("zero no relock", 32'(locked), 32'd0);
      end
      dsel = 2'd0;
      wait_lock(10, "self-sync relock");

      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      for (int m = 1; m < 4; m++) begin
         mode = 2'(m);
         tick();
         chk("mode change unlock", 32'(locked), 32'd0);
         wait_lock(1 + 4 + (m == 1 ? 2 : (m == 2 ? 3 : 4)), "mode relock");
         chk("mode err_cnt", 32'(err_cnt), 32'd0);
      end

      dsel = 2'd1;
      tick();
      dsel = 2'd0;
      tick();
      chk("PRBS31 inverted word", 32'(err_cnt), 32'd8);
      rst = 1'b1; clr_cnt = 1'b0;
      tick();
      chk("rst2 gen_data",  32'(gen_data),  32'h0);
      chk("rst2 gen_valid", 32'(gen_valid), 32'd0);
      chk("rst2 locked",    32'(locked),    32'd0);
      chk("rst2 err_cnt",   32'(err_cnt),   32'd0);
      chk("rst2 err_sat",   32'(err_sat),   32'd0);
      chk("rst2 locked4",   32'(locked4),   32'd0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
